// File: rtl/riscv_core_csr_trap_unit.sv
// Machine-mode CSR file and trap/mret sequencer with a one-cycle pipeline redirect.
// Define RISCV_CSR_COUNTERS_EN to build the mcycle/minstret counters.
module riscv_core_csr_trap_unit #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_MTVEC = XLEN'(64'h0000_0000_0000_0100)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic            i_mret,
  input  logic            i_csr_wen,
  input  logic            i_illegal,
  input  logic            i_irq_ext,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_stall,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_BREAK   = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_IRQ_EXT = {1'b1, (XLEN-1)'(11)};

  typedef enum logic {IDLE, REDIRECT} state_t;
  state_t state;

  logic            mstatus_mie, mstatus_mpie, mie_meie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause;
`ifdef RISCV_CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle, minstret;
`endif

  logic [11:0]     csr_addr;
  logic [2:0]      funct3;
  logic [4:0]      rs1_field;
  logic [XLEN-1:0] csr_old, csr_src, csr_new, trap_cause;
  logic            csr_known, csr_write, bad_csr;
  logic            active, take_irq, take_exc, take_trap, take_mret, do_csr, retire;
  logic            unused_bits;

  assign csr_addr    = i_instr[31:20];
  assign funct3      = i_instr[14:12];
  assign rs1_field   = i_instr[19:15];
  assign unused_bits = ^{i_instr[11:0], i_pc[0]};

  // Read mux: value of the addressed CSR before any write this cycle.
  always_comb begin
    csr_old   = '0;
    csr_known = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_old[3]     = mstatus_mie;
        csr_old[7]     = mstatus_mpie;
        csr_old[12:11] = 2'b11;
      end
      ADDR_MIE:      csr_old[11] = mie_meie;
      ADDR_MTVEC:    csr_old = mtvec;
      ADDR_MSCRATCH: csr_old = mscratch;
      ADDR_MEPC:     csr_old = mepc;
      ADDR_MCAUSE:   csr_old = mcause;
      ADDR_MIP:      csr_old[11] = i_irq_ext;
`ifdef RISCV_CSR_COUNTERS_EN
      ADDR_MCYCLE:   csr_old = mcycle;
      ADDR_MINSTRET: csr_old = minstret;
`else
      ADDR_MCYCLE, ADDR_MINSTRET: csr_old = '0;
`endif
      default:       csr_known = 1'b0;
    endcase
  end

  assign csr_src = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_field} : i_rs1_data;

  always_comb begin
    csr_new = csr_old;
    case (funct3[1:0])
      2'b01:   csr_new = csr_src;
      2'b10:   csr_new = csr_old | csr_src;
      2'b11:   csr_new = csr_old & ~csr_src;
      default: csr_new = csr_old;
    endcase
  end

  // RS/RC with a zero rs1/zimm field are pure reads and never count as writes.
  assign csr_write = (funct3[1:0] == 2'b01) || (rs1_field != 5'd0);
  assign bad_csr   = i_csr_wen && ((funct3[1:0] == 2'b00) ||
                     (csr_write && (!csr_known || csr_addr == ADDR_MIP)));

  assign active    = (state == IDLE) && i_valid;
  assign take_irq  = active && mstatus_mie && mie_meie && i_irq_ext;
  assign take_exc  = active && !take_irq && (i_illegal || bad_csr || i_ebreak || i_ecall);
  assign take_trap = take_irq || take_exc;
  assign take_mret = active && !take_trap && i_mret;
  assign do_csr    = active && !take_trap && !i_mret && i_csr_wen && csr_write;
  assign retire    = active && !take_trap;

  always_comb begin
    trap_cause = CAUSE_ECALL;
    if (take_irq)                  trap_cause = CAUSE_IRQ_EXT;
    else if (i_illegal || bad_csr) trap_cause = CAUSE_ILLEGAL;
    else if (i_ebreak)             trap_cause = CAUSE_BREAK;
  end

  assign o_stall     = take_trap || take_mret;
  assign o_csr_rdata = (active && i_csr_wen) ? csr_old : '0;

  // Sequencer: the redirect and its target are registered for the cycle after acceptance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_trap || take_mret) begin
            state         <= REDIRECT;
            o_redirect    <= 1'b1;
            o_redirect_pc <= take_trap ? mtvec : mepc;
          end
        end
        REDIRECT: begin
          state      <= IDLE;
          o_redirect <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          o_redirect <= 1'b0;
        end
      endcase
    end
  end

  // CSR state: trap entry beats mret, which beats an ordinary CSR write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= RESET_MTVEC;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
`ifdef RISCV_CSR_COUNTERS_EN
      mcycle       <= '0;
      minstret     <= '0;
`endif
    end else begin
      if (take_trap) begin
        mepc         <= {i_pc[XLEN-1:1], 1'b0};
        mcause       <= trap_cause;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (take_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (do_csr) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= csr_new[3];
            mstatus_mpie <= csr_new[7];
          end
          ADDR_MIE:      mie_meie <= csr_new[11];
          ADDR_MTVEC:    mtvec    <= {csr_new[XLEN-1:2], 2'b00};
          ADDR_MSCRATCH: mscratch <= csr_new;
          ADDR_MEPC:     mepc     <= {csr_new[XLEN-1:1], 1'b0};
          ADDR_MCAUSE:   mcause   <= csr_new;
          default: ;
        endcase
      end
`ifdef RISCV_CSR_COUNTERS_EN
      if (do_csr && csr_addr == ADDR_MCYCLE) mcycle <= csr_new;
      else                                   mcycle <= mcycle + XLEN'(1);
      if (do_csr && csr_addr == ADDR_MINSTRET) minstret <= csr_new;
      else if (retire)                         minstret <= minstret + XLEN'(1);
`endif
    end
  end

endmodule

// File: tb/tb_riscv_core_csr_trap_unit.sv
// Directed scoreboard bench for riscv_core_csr_trap_unit; expected values are queued when stimulus is driven.
module tb_riscv_core_csr_trap_unit;

  localparam int XLEN = 64;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [4:0] F_ECALL = 5'b10000, F_EBREAK = 5'b01000, F_MRET = 5'b00100, F_CSR = 5'b00010;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_valid, i_ecall, i_ebreak, i_mret, i_csr_wen, i_illegal;
  logic            i_irq_ext = 1'b0;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc, i_rs1_data;
  logic [XLEN-1:0] o_csr_rdata, o_redirect_pc;
  logic            o_stall, o_redirect;

  typedef struct { string tag; logic [63:0] value; } exp_t;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 i_clk = ~i_clk;

  riscv_core_csr_trap_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
    .i_rs1_data(i_rs1_data), .i_ecall(i_ecall), .i_ebreak(i_ebreak), .i_mret(i_mret),
    .i_csr_wen(i_csr_wen), .i_illegal(i_illegal), .i_irq_ext(i_irq_ext),
    .o_csr_rdata(o_csr_rdata), .o_stall(o_stall), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc)
  );

  function automatic logic [31:0] csr_instr(input logic [11:0] addr, input logic [4:0] rs1f,
                                            input logic [2:0] f3);
    return {addr, rs1f, f3, 5'd1, 7'h73};
  endfunction

  task automatic driveIdle();
    i_valid = 1'b0; i_instr = '0; i_pc = '0; i_rs1_data = '0;
    {i_ecall, i_ebreak, i_mret, i_csr_wen, i_illegal} = '0;
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the following falling edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [63:0] pc,
                               input logic [63:0] rs1, input logic [4:0] flags);
    i_valid = valid; i_instr = instr; i_pc = pc; i_rs1_data = rs1;
    {i_ecall, i_ebreak, i_mret, i_csr_wen, i_illegal} = flags;
    @(negedge i_clk);
  endtask

  task automatic finishCycle();
    @(posedge i_clk);
    #1;
    driveIdle();
  endtask

  task automatic expectValue(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.value = v;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [63:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: got %h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.value) else begin
        miscompares++;
        $error("[TB] FAIL %s: got %h, want %h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic checkNow(input string tag, input logic [63:0] exp, input logic [63:0] obs);
    expectValue(tag, exp);
    checkOutput(obs);
  endtask

  task automatic readCsr(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    applyStimulus(1'b1, csr_instr(addr, 5'd0, 3'b010), 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, F_CSR);
    checkNow(tag, exp, o_csr_rdata);
    finishCycle();
  endtask

  task automatic writeCsr(input string tag, input logic [11:0] addr, input logic [2:0] f3,
                          input logic [4:0] rs1f, input logic [63:0] data, input logic [63:0] old);
    applyStimulus(1'b1, csr_instr(addr, rs1f, f3), 64'h1000, data, F_CSR);
    checkNow({tag, "_old"}, old, o_csr_rdata);
    checkNow({tag, "_stall"}, 64'd0, {63'd0, o_stall});
    finishCycle();
  endtask

  task automatic trapEvent(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                           input logic [4:0] flags, input logic [63:0] target, input bit want_redirect);
    applyStimulus(1'b1, instr, pc, 64'h0, flags);
    checkNow({tag, "_stall"}, 64'd1, {63'd0, o_stall});
    checkNow({tag, "_early_redir"}, 64'd0, {63'd0, o_redirect});
    if (want_redirect) begin
      expectValue({tag, "_redir"}, 64'd1);
      expectValue({tag, "_target"}, target);
    end
    finishCycle();
  endtask

  // Redirect cycle, optionally with a retiring ecall that must be flushed, then the drop of redirect.
  task automatic redirectCycle(input string tag, input bit flush_valid);
    if (flush_valid) begin
      i_valid = 1'b1; i_instr = ECALL; i_ecall = 1'b1; i_pc = 64'h900;
    end
    @(negedge i_clk);
    checkOutput({63'd0, o_redirect});
    checkOutput(o_redirect_pc);
    checkNow({tag, "_redir_stall"}, 64'd0, {63'd0, o_stall});
    finishCycle();
    @(negedge i_clk);
    checkNow({tag, "_redir_drop"}, 64'd0, {63'd0, o_redirect});
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    driveIdle();
    @(negedge i_clk);
    checkNow("rst_stall", 64'd0, {63'd0, o_stall});
    checkNow("rst_redir", 64'd0, {63'd0, o_redirect});
    checkNow("rst_redir_pc", 64'd0, o_redirect_pc);
    checkNow("rst_rdata", 64'd0, o_csr_rdata);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    readCsr("rst_mtvec", 12'h305, 64'h100);
    readCsr("rst_mstatus", 12'h300, 64'h1800);

    trapEvent("ecall", ECALL, 64'h80, F_ECALL, 64'h100, 1'b1);
    redirectCycle("ecall", 1'b0);
    readCsr("ecall_mcause", 12'h342, 64'd11);
    readCsr("ecall_mepc", 12'h341, 64'h80);
    readCsr("ecall_mstatus", 12'h300, 64'h1800);

    writeCsr("mscratch_rw", 12'h340, 3'b001, 5'd5, 64'hDEAD, 64'd0);
    writeCsr("mscratch_rs0", 12'h340, 3'b010, 5'd0, 64'hFFFF, 64'hDEAD);
    readCsr("mscratch_keep", 12'h340, 64'hDEAD);
    writeCsr("mscratch_rc", 12'h340, 3'b011, 5'd1, 64'h00AD, 64'hDEAD);
    writeCsr("mscratch_rsi", 12'h340, 3'b110, 5'd5, 64'h0, 64'hDE00);
    readCsr("mscratch_final", 12'h340, 64'hDE05);

    writeCsr("mtvec_rw", 12'h305, 3'b001, 5'd1, 64'h403, 64'h100);
    readCsr("mtvec_align", 12'h305, 64'h400);
    writeCsr("mie_rw", 12'h304, 3'b001, 5'd1, 64'hFFFF, 64'd0);
    readCsr("mie_meie", 12'h304, 64'h800);
    writeCsr("mstatus_mie", 12'h300, 3'b110, 5'd8, 64'h0, 64'h1800);
    readCsr("mstatus_set", 12'h300, 64'h1808);

    i_irq_ext = 1'b1;
    trapEvent("irq", EBREAK, 64'h300, F_EBREAK, 64'h400, 1'b1);
    i_irq_ext = 1'b0;
    redirectCycle("irq", 1'b0);
    readCsr("irq_mcause", 12'h342, 64'h8000_0000_0000_000B);
    readCsr("irq_mepc", 12'h341, 64'h300);
    readCsr("irq_mstatus", 12'h300, 64'h1880);
    i_irq_ext = 1'b1;
    readCsr("mip_level", 12'h344, 64'h800);
    i_irq_ext = 1'b0;

    writeCsr("mepc_rw", 12'h341, 3'b001, 5'd1, 64'h2003, 64'h300);
    readCsr("mepc_align", 12'h341, 64'h2002);
    trapEvent("mret", MRET, 64'h500, F_MRET, 64'h2002, 1'b1);
    redirectCycle("mret", 1'b1);
    readCsr("mret_mstatus", 12'h300, 64'h1888);
    readCsr("mret_flush_mcause", 12'h342, 64'h8000_0000_0000_000B);
    readCsr("mret_flush_mepc", 12'h341, 64'h2002);

    trapEvent("bad_addr", csr_instr(12'h7C0, 5'd1, 3'b001), 64'h600, F_CSR, 64'h400, 1'b1);
    redirectCycle("bad_addr", 1'b0);
    readCsr("bad_addr_mcause", 12'h342, 64'd2);
    readCsr("bad_addr_mepc", 12'h341, 64'h600);
    readCsr("bad_addr_mstatus", 12'h300, 64'h1880);

    writeCsr("mcause_rw", 12'h342, 3'b001, 5'd1, 64'h55, 64'd2);
    trapEvent("mip_wr", csr_instr(12'h344, 5'd1, 3'b001), 64'h700, F_CSR, 64'h400, 1'b1);
    redirectCycle("mip_wr", 1'b0);
    readCsr("mip_wr_mcause", 12'h342, 64'd2);
    readCsr("mip_wr_mepc", 12'h341, 64'h700);

    trapEvent("rstmid", ECALL, 64'h800, F_ECALL, 64'h0, 1'b0);
    #2;
    checkNow("rstmid_pre", 64'd1, {63'd0, o_redirect});
    i_rst = 1'b1;
    #1;
    checkNow("rstmid_redir", 64'd0, {63'd0, o_redirect});
    checkNow("rstmid_pc", 64'd0, o_redirect_pc);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    readCsr("rstmid_mtvec", 12'h305, 64'h100);
    readCsr("rstmid_mscratch", 12'h340, 64'd0);
    readCsr("rstmid_mstatus", 12'h300, 64'h1800);

`ifdef RISCV_CSR_COUNTERS_EN
    applyStimulus(1'b1, csr_instr(12'hB00, 5'd1, 3'b001), 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, F_CSR);
    checkNow("mcycle_wr_stall", 64'd0, {63'd0, o_stall});
    finishCycle();
    @(posedge i_clk);
    #1;
    readCsr("mcycle_wrap", 12'hB00, 64'd0);
    applyStimulus(1'b1, csr_instr(12'hB02, 5'd1, 3'b001), 64'h1000, 64'd5, F_CSR);
    finishCycle();
    readCsr("minstret_wr", 12'hB02, 64'd5);
`else
    readCsr("mcycle_zero", 12'hB00, 64'd0);
    writeCsr("mcycle_wr", 12'hB00, 3'b001, 5'd1, 64'h1234, 64'd0);
    readCsr("mcycle_still_zero", 12'hB00, 64'd0);
    readCsr("minstret_zero", 12'hB02, 64'd0);
`endif

    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_core_csr_trap_unit.md
# riscv_core_csr_trap_unit

Machine-mode CSR file and trap sequencer for the RV64 core, directly downstream of the CSR instruction decoder. It takes the decoder's ecall/ebreak/mret/CSR-write/illegal indications together with the retiring instruction, then executes Zicsr read-modify-writes. It also sequences trap entry and `mret` return, and issues a one-cycle pipeline redirect to `mtvec` or `mepc`.

## Interface
- `XLEN`, 64: register width.
- `RESET_MTVEC`, 64'h0000_0000_0000_0100: reset value of `mtvec`.
- `i_clk` input 1: core clock.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_valid` input 1: instruction in this stage is retiring this cycle.
- `i_instr` input 32: the instruction itself.
- `i_pc` input XLEN: PC of that instruction.
- `i_rs1_data` input XLEN: rs1 operand.
- `i_ecall`, `i_ebreak`, `i_mret`, `i_csr_wen`, `i_illegal` input 1 each: decoder outputs for `i_instr`.
- `i_irq_ext` input 1: level-sensitive machine external interrupt.
- `o_csr_rdata` output XLEN: old CSR value, written to rd.
- `o_stall` output 1: hold upstream stages this cycle.
- `o_redirect` output 1: flush the pipeline and fetch from `o_redirect_pc`.
- `o_redirect_pc` output XLEN: redirect target.

## Operation
- **Implemented CSRs:**
  - `mstatus` 0x300: MIE is bit 3, MPIE is bit 7, MPP bits 12:11 read 2'b11, all other bits read 0.
  - `mie` 0x304: only MEIE, bit 11, is writable.
  - `mtvec` 0x305: direct mode only, bits [1:0] forced 0.
  - `mscratch` 0x340.
  - `mepc` 0x341: bit 0 forced 0.
  - `mcause` 0x342.
  - `mip` 0x344: read-only; bit 11 = `i_irq_ext`.
  - `mcycle` 0xB00 and `minstret` 0xB02: see Configuration.
- **CSR access:** address is `i_instr[31:20]` and funct3 is `i_instr[14:12]`.
  - Source is `i_rs1_data` for funct3 001/010/011, and zero-extended `i_instr[19:15]` for 101/110/111.
  - RW writes src. RS writes old|src. RC writes old&~src.
  - RS/RC with rs1/zimm field = 0 perform no write.
  - A write to `mip` or to an unimplemented address is illegal.
- **Exception causes:**
  - `i_illegal` → 2.
  - Bad CSR access → 2.
  - `i_ebreak` → 3.
  - `i_ecall` → 11.
- **Interrupt:** taken when `i_valid` & `mstatus.MIE` & `mie.MEIE` & `i_irq_ext`, with mcause = {1'b1, 63'd11}. The instruction is not executed.
- **Priority within an `i_valid` cycle:** interrupt, then exception, then `mret`, then CSR access.
- **Trap entry:** mepc←`i_pc`, mcause←cause, MPIE←MIE, MIE←0, target←`mtvec`.
- **`mret`:** MIE←MPIE, MPIE←1, target←`mepc`.
- **FSM:**
  - IDLE: a trap or `mret` on `i_valid` moves to REDIRECT; otherwise stay in IDLE.
  - REDIRECT: unconditionally returns to IDLE after one cycle.
- **Retirement and counting:**
  - An instruction that traps does not retire.
  - `mret` and CSR instructions do retire.
  - `minstret` counts retirements.

## Timing
- **Reset values:**
  - FSM resets to IDLE.
  - All CSRs reset to 0, except `mtvec` = `RESET_MTVEC`.
  - `o_stall`, `o_redirect`, `o_redirect_pc` and `o_csr_rdata` all reset to 0.
- **CSR reads:** `o_csr_rdata` is combinational and reflects the pre-write value. CSR writes commit at the rising edge ending cycle N.
- **Trap or `mret` accepted in cycle N:**
  - `o_stall`=1 combinationally in N.
  - CSR updates commit at the N edge.
  - `o_redirect`=1 for exactly cycle N+1, with a registered `o_redirect_pc`.
- **During REDIRECT:**
  - `i_valid` is ignored; that instruction is being flushed.
  - No retirement and no trap.
  - `o_stall`=0.
- **Asynchronous reset mid-REDIRECT:** `o_redirect` drops immediately and the pending redirect is lost.
- **Interrupt deassertion:** `i_irq_ext` dropping during REDIRECT has no effect on the committed trap.
- **Back-to-back events:** a new trap cannot be accepted until the cycle after REDIRECT. Minimum spacing is 2 cycles.

## Configuration
- `RISCV_CSR_COUNTERS_EN` defined:
  - `mcycle` increments every cycle, including REDIRECT.
  - `minstret` increments on retirement.
  - Both wrap from 2^64−1 to 0.
  - A CSR write in the same cycle overrides the increment for that counter.
- `RISCV_CSR_COUNTERS_EN` undefined:
  - Addresses 0xB00/0xB02 read 0 and ignore writes, and are not illegal.
  - No counter flops are synthesized.

## Test plan
- Reset with `RESET_MTVEC`=0x100, then `ecall` (0x00000073) at pc 0x80 → `o_stall` in N; mcause=11, mepc=0x80, MIE=0; `o_redirect`=1 with target 0x100 in N+1 only.
- `csrrw x0, mscratch` with rs1=0xDEAD → `o_csr_rdata`=0 that cycle. Then `csrrs` on mscratch with rs1 field 0 → reads 0xDEAD and mscratch stays 0xDEAD.
- Set MIE=1 and MEIE=1, then raise `i_irq_ext` with `i_valid` and an `ebreak` in flight → interrupt wins: mcause=0x8000_0000_0000_000B, no retirement.
- `mret` with mepc=0x2002 and MPIE=1 → redirect to 0x2002, MIE=1, MPIE=1. `i_valid` during REDIRECT is ignored.
- `csrrw` to 0x7C0, and separately a write to `mip` → trap with mcause=2.
- With `RISCV_CSR_COUNTERS_EN`: write `mcycle`=0xFFFF_FFFF_FFFF_FFFF → reads 0 two cycles later. Without it: `mcycle` reads 0.
